// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for a 640x480@60 Hz VGA display clocked by the
// 25 MHz pixel clock. Two free-running counters walk the full raster (active
// area plus porches and sync). Every output is a registered decode of the
// counter values *before* they advance. This gives one clock of latency from
// counter to pin, and it keeps the sync outputs driven directly by flops.
//
// There is no valid/ready handshake on this block. Consumers sample o_x/o_y
// on every clock and gate on o_video. o_line_start and o_frame_start are
// single-clock strobes that mark the first pixel of a line and of a frame.

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          i_clk25m,
  input  logic          i_rst_clk25m,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_video,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start
);

  // Every boundary is stored as an inclusive "last" value. That keeps each
  // constant inside the counter range, even when a porch is zero or a total
  // is an exact power of two.
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] HS_FIRST   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] VS_FIRST   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_q, video_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic h_wrap;
  logic hs_on;
  logic vs_on;

  // Raster counters: h wraps at the end of the line, and v advances only on an h wrap.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_cnt_q + XW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + YW'(1);
      end
    end
  end

  // Decode the current (pre-increment) position into the next output values.
  always_comb begin
    hs_on         = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    vs_on         = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    hsync_d       = hs_on ? H_POL : ~H_POL;
    vsync_d       = vs_on ? V_POL : ~V_POL;
    video_d       = (h_cnt_q <= H_ACT_LAST) && (v_cnt_q <= V_ACT_LAST);
    x_d           = h_cnt_q;
    y_d           = v_cnt_q;
    line_start_d  = (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // State and output registers. Reset takes effect on the very next edge, so
  // a sync pulse that is in progress is cut off rather than extended.
  always_ff @(posedge i_clk25m) begin
    if (i_rst_clk25m) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      video_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_q       <= video_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_video       = video_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview: Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It sits inside the VGA display interface, directly downstream of the clock wizard and the reset synchronizer. It produces hsync, vsync, pixel coordinates, the active-video flag, and line/frame strobes that the pixel/colour stage consumes. All outputs are registered.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low)
V_POL, 0, vsync asserted level (0 = active-low)
Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).

Ports:
i_clk25m  in  1  25 MHz pixel clock; the only clock
i_rst_clk25m  in  1  reset, synchronous, active-high
o_hsync  out  1  horizontal sync, polarity per H_POL
o_vsync  out  1  vertical sync, polarity per V_POL
o_video  out  1  1 while the pixel is in the visible area
o_x  out  XW  horizontal position, 0..H_TOTAL-1
o_y  out  YW  vertical position, 0..V_TOTAL-1
o_line_start  out  1  one-clock pulse at h=0 of every line
o_frame_start  out  1  one-clock pulse at h=0, v=0

Behaviour:
- Internal counters h_cnt (XW bits) and v_cnt (YW bits).
- Reset, sampled on a clock edge while i_rst_clk25m=1:
  - h_cnt=0, v_cnt=0.
  - o_hsync=~H_POL, o_vsync=~V_POL (deasserted).
  - o_video=0, o_x=0, o_y=0, o_line_start=0, o_frame_start=0.
- Counting, on each edge with reset low:
  - If h_cnt==H_TOTAL-1: h_cnt wraps to 0.
    - v_cnt also wraps to 0 if v_cnt==V_TOTAL-1; otherwise v_cnt increments.
  - Otherwise h_cnt increments and v_cnt holds.
- Outputs are registered decodes of the pre-increment counter values, so latency is 1 clock from counter to pin.
  - Index the edges with reset low as k = 0, 1, 2, ...
  - After edge k, the outputs describe pixel k: x = k mod H_TOTAL, y = (k div H_TOTAL) mod V_TOTAL.
- Decode, for position (h, v):
  - video = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line including blanking.
  - line_start = (h==0); frame_start = (h==0 && v==0).
- o_x and o_y carry the raw counter values in blanking as well; consumers gate on o_video.
- Defaults give 800 clocks/line and 525 lines/frame, i.e. 420000 clocks/frame:
  - hsync asserted for x = 656..751.
  - vsync asserted for y = 490..491.
- Reset mid-frame: on the next edge with reset high, all outputs and counters return to reset values, with no partial pulse extension. After release, pixel (0,0) is output on the first edge, with o_line_start=o_frame_start=1.
- Widths: counter compares are done at XW/YW width; there is no overflow, because wrap occurs at TOTAL-1.
- Sync outputs are glitch-free (flop-driven) and change only on the clock edge.

Test Plan:
- Hold reset 5 clocks, then check during reset: o_hsync=1, o_vsync=1, o_video=0, o_x=0, o_y=0, both strobes 0.
- Release reset. Edge 0: o_x=0, o_y=0, o_video=1, o_line_start=1, o_frame_start=1. Edge 639: o_video=1. Edge 640: o_video=0.
- Over line 0: o_hsync goes low at x=656 and high at x=752, giving 96 low clocks. o_line_start repeats every 800 clocks.
- Full frame: o_vsync is low exactly for y=490..491, i.e. 1600 clocks. o_frame_start pulses are 420000 clocks apart. o_y wraps 524->0 together with o_x wrapping 799->0.
- Assert reset for 1 clock at x=300, y=200: the next output has reset values. The first edge after release gives x=0, y=0, frame_start=1.
- Small config (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1):
  - frame period = 14*7 = 98 clocks.
  - hsync high for x=10..12.
  - vsync low for y=5.
